// File: rtl/pipemem_if.sv
// rtl/pipemem_if.sv - data-memory port bundle between the memory stage and data memory
//
// Purpose: groups the word-wide data-memory request/ready handshake.
// Signals:
//   req    access request (master -> slave)
//   we     1 = store, 0 = load (master -> slave)
//   addr   word address (master -> slave)
//   wdata  store data (master -> slave)
//   ready  memory completes the current request this cycle (slave -> master)
//   rdata  load data, valid only with ready (slave -> master)
interface pipemem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  ready,
    input  rdata
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output ready,
    output rdata
  );
endinterface

// File: rtl/pipemem.sv
// rtl/pipemem.sv - memory stage: EXE/MEM register, data-memory handshake, stall and abort
//
// Purpose: holds the EXE/MEM pipeline register, issues word accesses on the
// data-memory port, stalls upstream stages while an access is outstanding and
// aborts misaligned or timed-out accesses (raising sticky merr).
// Ports:
//   clk, clrn                 clock, synchronous active-low reset
//   ewreg, em2reg, ewmem      execute-stage reg-write / load / store controls
//   ealu, eb, ern             execute-stage ALU result (address), store data, dest reg
//   dmem                      data-memory port (master side)
//   mwreg, mm2reg, mrn, malu  toward MEM/WB and forwarding
//   mmo                       load data (pass-through of dmem rdata)
//   mstall                    freeze upstream stages and this register
//   merr                      sticky misaligned/timeout error
module pipemem #(
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic             ewmem,
  input  logic [31:0]      ealu,
  input  logic [31:0]      eb,
  input  logic [4:0]       ern,
  pipemem_if.master        dmem,
  output logic             mwreg,
  output logic             mm2reg,
  output logic [4:0]       mrn,
  output logic [31:0]      malu,
  output logic [31:0]      mmo,
  output logic             mstall,
  output logic             merr
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        merr_q, merr_d;

  logic        mwreg_r_q, mwreg_r_d;
  logic        mm2reg_q, mm2reg_d;
  logic        mwmem_q, mwmem_d;
  logic [31:0] malu_q, malu_d;
  logic [31:0] mb_q, mb_d;
  logic [4:0]  mrn_q, mrn_d;

  logic memop;
  logic aligned;
  logic req;
  logic stall;
  logic abort;

  assign memop   = mm2reg_q | mwmem_q;
  assign aligned = (malu_q[1:0] == 2'b00);

  always_comb begin
    req     = 1'b0;
    stall   = 1'b0;
    abort   = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    merr_d  = merr_q;
    case (state_q)
      S_IDLE: begin
        if (memop) begin
          if (aligned) begin
            req = 1'b1;
            if (!dmem.ready) begin
              stall   = 1'b1;
              cnt_d   = 8'd1;
              state_d = S_WAIT;
            end
          end else begin
            // Misaligned: never reaches memory, retires without a write.
            abort  = 1'b1;
            merr_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (dmem.ready) begin
          req     = 1'b1;
          cnt_d   = 8'd0;
          state_d = S_IDLE;
        end else if (cnt_q == TIMEOUT_CNT) begin
          // The IDLE cycle plus WAIT cycles cnt=1..TIMEOUT-1 gives exactly
          // TIMEOUT stalled cycles; this is the release cycle.
          abort   = 1'b1;
          merr_d  = 1'b1;
          cnt_d   = 8'd0;
          state_d = S_IDLE;
        end else begin
          req   = 1'b1;
          stall = 1'b1;
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_comb begin
    mwreg_r_d = mwreg_r_q;
    mm2reg_d  = mm2reg_q;
    mwmem_d   = mwmem_q;
    malu_d    = malu_q;
    mb_d      = mb_q;
    mrn_d     = mrn_q;
    if (!stall) begin
      mwreg_r_d = ewreg;
      mm2reg_d  = em2reg;
      mwmem_d   = ewmem;
      malu_d    = ealu;
      mb_d      = eb;
      mrn_d     = ern;
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      merr_q    <= 1'b0;
      mwreg_r_q <= 1'b0;
      mm2reg_q  <= 1'b0;
      mwmem_q   <= 1'b0;
      malu_q    <= 32'd0;
      mb_q      <= 32'd0;
      mrn_q     <= 5'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      merr_q    <= merr_d;
      mwreg_r_q <= mwreg_r_d;
      mm2reg_q  <= mm2reg_d;
      mwmem_q   <= mwmem_d;
      malu_q    <= malu_d;
      mb_q      <= mb_d;
      mrn_q     <= mrn_d;
    end
  end

  assign dmem.req   = req;
  assign dmem.we    = mwmem_q;
  assign dmem.addr  = malu_q;
  assign dmem.wdata = mb_q;

  assign mwreg  = mwreg_r_q & ~stall & ~abort;
  assign mm2reg = mm2reg_q;
  assign mrn    = mrn_q;
  assign malu   = malu_q;
  assign mmo    = dmem.rdata;
  assign mstall = stall;
  assign merr   = merr_q;

endmodule

// File: tb/tb_pipemem.sv
// tb/tb_pipemem.sv - directed self-checking bench for pipemem
module tb_pipemem;
  logic        clk;
  logic        clrn;
  logic        ewreg, em2reg, ewmem;
  logic [31:0] ealu, eb;
  logic [4:0]  ern;
  logic        mwreg, mm2reg, mstall, merr;
  logic [4:0]  mrn;
  logic [31:0] malu, mmo;

  int checks = 0;
  int errors = 0;

  pipemem_if bus ();

  pipemem #(.TIMEOUT(4)) dut (
    .clk    (clk),
    .clrn   (clrn),
    .ewreg  (ewreg),
    .em2reg (em2reg),
    .ewmem  (ewmem),
    .ealu   (ealu),
    .eb     (eb),
    .ern    (ern),
    .dmem   (bus),
    .mwreg  (mwreg),
    .mm2reg (mm2reg),
    .mrn    (mrn),
    .malu   (malu),
    .mmo    (mmo),
    .mstall (mstall),
    .merr   (merr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance past the next rising edge; inputs are then changed and outputs
  // sampled mid-cycle, well away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_e(input logic w, input logic l, input logic s,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
    ewreg = w; em2reg = l; ewmem = s; ealu = a; eb = b; ern = r;
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    set_e(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0, 5'd7);
    bus.ready = 1'b0; bus.rdata = 32'h0;
    step(); step();
    #1;
    checks++; if (mwreg !== 1'b0) begin errors++; $display("FAIL reset_mwreg got %h exp 0", mwreg); end
    checks++; if (malu !== 32'h0) begin errors++; $display("FAIL reset_malu got %h exp 0", malu); end
    checks++; if (mrn !== 5'd0) begin errors++; $display("FAIL reset_mrn got %h exp 0", mrn); end
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL reset_req got %h exp 0", bus.req); end
    checks++; if (mstall !== 1'b0) begin errors++; $display("FAIL reset_mstall got %h exp 0", mstall); end
    checks++; if (merr !== 1'b0) begin errors++; $display("FAIL reset_merr got %h exp 0", merr); end
    clrn = 1'b1;
    set_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
  endtask

  task automatic test_alu();
    set_e(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd5);
    step();
    set_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    checks++; if (mwreg !== 1'b1) begin errors++; $display("FAIL alu_mwreg got %h exp 1", mwreg); end
    checks++; if (malu !== 32'h0000_1234) begin errors++; $display("FAIL alu_malu got %h exp 00001234", malu); end
    checks++; if (mrn !== 5'd5) begin errors++; $display("FAIL alu_mrn got %0d exp 5", mrn); end
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL alu_req got %h exp 0", bus.req); end
    checks++; if (mstall !== 1'b0) begin errors++; $display("FAIL alu_mstall got %h exp 0", mstall); end
  endtask

  task automatic test_load_zero_wait();
    set_e(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd7);
    step();
    set_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    bus.ready = 1'b1; bus.rdata = 32'hCAFE_F00D;
    #1;
    checks++; if (bus.req !== 1'b1) begin errors++; $display("FAIL ld0_req got %h exp 1", bus.req); end
    checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL ld0_we got %h exp 0", bus.we); end
    checks++; if (bus.addr !== 32'h100) begin errors++; $display("FAIL ld0_addr got %h exp 00000100", bus.addr); end
    checks++; if (mmo !== 32'hCAFE_F00D) begin errors++; $display("FAIL ld0_mmo got %h exp cafef00d", mmo); end
    checks++; if (mwreg !== 1'b1) begin errors++; $display("FAIL ld0_mwreg got %h exp 1", mwreg); end
    checks++; if (mm2reg !== 1'b1) begin errors++; $display("FAIL ld0_mm2reg got %h exp 1", mm2reg); end
    checks++; if (mstall !== 1'b0) begin errors++; $display("FAIL ld0_mstall got %h exp 0", mstall); end
    step();
    bus.ready = 1'b0;
    #1;
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL ld0_after_req got %h exp 0", bus.req); end
  endtask

  task automatic test_store_wait();
    set_e(1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h55AA_55AA, 5'd0);
    step();
    set_e(1'b1, 1'b0, 1'b0, 32'h0000_0300, 32'h0, 5'd9);
    bus.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (mstall !== 1'b1) begin errors++; $display("FAIL st_stall%0d got %h exp 1", i, mstall); end
      checks++; if (bus.req !== 1'b1) begin errors++; $display("FAIL st_req%0d got %h exp 1", i, bus.req); end
      checks++; if (bus.we !== 1'b1) begin errors++; $display("FAIL st_we%0d got %h exp 1", i, bus.we); end
      checks++; if (bus.wdata !== 32'h55AA_55AA) begin errors++; $display("FAIL st_wdata%0d got %h exp 55aa55aa", i, bus.wdata); end
      checks++; if (bus.addr !== 32'h200) begin errors++; $display("FAIL st_addr%0d got %h exp 00000200", i, bus.addr); end
      checks++; if (mwreg !== 1'b0) begin errors++; $display("FAIL st_mwreg%0d got %h exp 0", i, mwreg); end
      step();
    end
    bus.ready = 1'b1;
    #1;
    checks++; if (mstall !== 1'b0) begin errors++; $display("FAIL st_ready_stall got %h exp 0", mstall); end
    checks++; if (bus.req !== 1'b1) begin errors++; $display("FAIL st_ready_req got %h exp 1", bus.req); end
    checks++; if (malu !== 32'h200) begin errors++; $display("FAIL st_hold_malu got %h exp 00000200", malu); end
    step();
    bus.ready = 1'b0;
    set_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    checks++; if (malu !== 32'h300) begin errors++; $display("FAIL st_next_malu got %h exp 00000300", malu); end
    checks++; if (mrn !== 5'd9) begin errors++; $display("FAIL st_next_mrn got %0d exp 9", mrn); end
    checks++; if (mwreg !== 1'b1) begin errors++; $display("FAIL st_next_mwreg got %h exp 1", mwreg); end
    checks++; if (mstall !== 1'b0) begin errors++; $display("FAIL st_next_stall got %h exp 0", mstall); end
  endtask

  task automatic test_misaligned();
    set_e(1'b1, 1'b1, 1'b0, 32'h0000_0102, 32'h0, 5'd3);
    step();
    set_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    bus.ready = 1'b0;
    #1;
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL mis_req got %h exp 0", bus.req); end
    checks++; if (mstall !== 1'b0) begin errors++; $display("FAIL mis_stall got %h exp 0", mstall); end
    checks++; if (mwreg !== 1'b0) begin errors++; $display("FAIL mis_mwreg got %h exp 0", mwreg); end
    checks++; if (merr !== 1'b0) begin errors++; $display("FAIL mis_merr_early got %h exp 0", merr); end
    step();
    #1;
    checks++; if (merr !== 1'b1) begin errors++; $display("FAIL mis_merr got %h exp 1", merr); end
    step();
    #1;
    checks++; if (merr !== 1'b1) begin errors++; $display("FAIL mis_merr_sticky got %h exp 1", merr); end
  endtask

  task automatic test_timeout();
    clrn = 1'b0;
    step();
    clrn = 1'b1;
    #1;
    checks++; if (merr !== 1'b0) begin errors++; $display("FAIL to_merr_cleared got %h exp 0", merr); end
    set_e(1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 5'd4);
    step();
    set_e(1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'h0, 5'd6);
    bus.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (mstall !== 1'b1) begin errors++; $display("FAIL to_stall%0d got %h exp 1", i, mstall); end
      checks++; if (bus.req !== 1'b1) begin errors++; $display("FAIL to_req%0d got %h exp 1", i, bus.req); end
      step();
    end
    #1;
    checks++; if (mstall !== 1'b0) begin errors++; $display("FAIL to_release_stall got %h exp 0", mstall); end
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL to_release_req got %h exp 0", bus.req); end
    checks++; if (mwreg !== 1'b0) begin errors++; $display("FAIL to_release_mwreg got %h exp 0", mwreg); end
    checks++; if (merr !== 1'b0) begin errors++; $display("FAIL to_release_merr got %h exp 0", merr); end
    step();
    set_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    checks++; if (merr !== 1'b1) begin errors++; $display("FAIL to_merr got %h exp 1", merr); end
    checks++; if (malu !== 32'h44) begin errors++; $display("FAIL to_next_malu got %h exp 00000044", malu); end
    checks++; if (mrn !== 5'd6) begin errors++; $display("FAIL to_next_mrn got %0d exp 6", mrn); end
    checks++; if (mwreg !== 1'b1) begin errors++; $display("FAIL to_next_mwreg got %h exp 1", mwreg); end
  endtask

  task automatic test_back_to_back();
    set_e(1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 5'd1);
    step();
    set_e(1'b0, 1'b0, 1'b1, 32'h0000_0504, 32'h1234_5678, 5'd0);
    bus.ready = 1'b1; bus.rdata = 32'h0000_0011;
    #1;
    checks++; if (bus.addr !== 32'h500) begin errors++; $display("FAIL b2b_addr0 got %h exp 00000500", bus.addr); end
    checks++; if (mwreg !== 1'b1) begin errors++; $display("FAIL b2b_mwreg0 got %h exp 1", mwreg); end
    checks++; if (mmo !== 32'h11) begin errors++; $display("FAIL b2b_mmo0 got %h exp 00000011", mmo); end
    step();
    set_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    checks++; if (bus.req !== 1'b1) begin errors++; $display("FAIL b2b_req1 got %h exp 1", bus.req); end
    checks++; if (bus.addr !== 32'h504) begin errors++; $display("FAIL b2b_addr1 got %h exp 00000504", bus.addr); end
    checks++; if (bus.we !== 1'b1) begin errors++; $display("FAIL b2b_we1 got %h exp 1", bus.we); end
    checks++; if (bus.wdata !== 32'h1234_5678) begin errors++; $display("FAIL b2b_wdata1 got %h exp 12345678", bus.wdata); end
    checks++; if (mstall !== 1'b0) begin errors++; $display("FAIL b2b_stall1 got %h exp 0", mstall); end
    checks++; if (mwreg !== 1'b0) begin errors++; $display("FAIL b2b_mwreg1 got %h exp 0", mwreg); end
    step();
    #1;
    // ready high with no request pending must not stall or start anything
    checks++; if (mstall !== 1'b0) begin errors++; $display("FAIL b2b_idle_ready_stall got %h exp 0", mstall); end
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL b2b_idle_ready_req got %h exp 0", bus.req); end
    bus.ready = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    set_e(1'b1, 1'b1, 1'b0, 32'h0000_0600, 32'h0, 5'd2);
    step();
    set_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    bus.ready = 1'b0;
    #1;
    checks++; if (mstall !== 1'b1) begin errors++; $display("FAIL rw_stall got %h exp 1", mstall); end
    step();
    clrn = 1'b0;
    step();
    clrn = 1'b1;
    #1;
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL rw_req got %h exp 0", bus.req); end
    checks++; if (mstall !== 1'b0) begin errors++; $display("FAIL rw_stall_after got %h exp 0", mstall); end
    checks++; if (merr !== 1'b0) begin errors++; $display("FAIL rw_merr got %h exp 0", merr); end
    step();
    #1;
    checks++; if (merr !== 1'b0) begin errors++; $display("FAIL rw_merr_later got %h exp 0", merr); end
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL rw_req_later got %h exp 0", bus.req); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_zero_wait();
    test_store_wait();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipemem.md
# pipemem

Memory stage of the five-stage pipeline. It holds the EXE/MEM pipeline register, drives a word-wide data-memory port with a ready handshake, and stalls the upstream stages while an access is outstanding. It also aborts accesses that are misaligned or time out. Inputs come straight from the execute stage: ALU result, store data, destination register and control bits. Outputs feed the MEM/WB register and the forwarding unit.

## Interface
- TIMEOUT, 255: number of stalled cycles allowed for one access before abort; legal range 1..255.
- clk  in  1  pipeline clock, rising edge.
- clrn  in  1  reset; one clock, reset is synchronous and active-low.
- ewreg, em2reg, ewmem  in  1 each  execute-stage register-write, load, and store controls.
- ealu  in  32  execute-stage ALU result, used as the memory address.
- eb  in  32  execute-stage store data.
- ern  in  5  execute-stage destination register.
- dmem_ready  in  1  memory completes the current request this cycle.
- dmem_rdata  in  32  load data; valid only with dmem_ready.
- dmem_req  out  1  access request.
- dmem_we  out  1  store when 1, load when 0.
- dmem_addr  out  32  word address, equal to malu.
- dmem_wdata  out  32  store data, equal to mb.
- mwreg  out  1  register write toward write-back; suppressed while stalled or aborted.
- mm2reg  out  1  registered load flag.
- mrn  out  5  registered destination register.
- malu  out  32  registered ALU result.
- mmo  out  32  load data; equals dmem_rdata.
- mstall  out  1  freeze PC, IF/ID and ID/EXE; this block's EXE/MEM register also holds.
- merr  out  1  sticky error: misaligned access or timeout.

## Operation
- EXE/MEM register fields: mwreg_r, mm2reg, mwmem, malu, mb, mrn.
  - Loaded on each rising edge when mstall=0.
  - Held when mstall=1.
- memop = mm2reg | mwmem.
- aligned = (malu[1:0] == 0).
- FSM states are IDLE and WAIT, with an 8-bit counter cnt.
- IDLE, memop & aligned:
  - Drive dmem_req=1, dmem_we=mwmem.
  - If dmem_ready=1: the access completes this cycle, mstall=0, stay in IDLE.
  - Else: mstall=1, cnt<=1, go to WAIT.
- IDLE, memop & !aligned:
  - dmem_req=0, mstall=0, merr<=1.
  - The instruction retires with mwreg=0.
- WAIT:
  - If dmem_ready=1: dmem_req=1, mstall=0, cnt<=0, go to IDLE.
  - Else if cnt==TIMEOUT: abort with dmem_req=0, mstall=0, merr<=1, mwreg=0, cnt<=0, go to IDLE.
  - Else: dmem_req=1, mstall=1, cnt<=cnt+1.
- mwreg = mwreg_r & ~mstall & ~abort, where abort is the misaligned or timeout release cycle.
- Non-memory instructions pass through in one cycle and never stall.
- merr is cleared only by reset.
- Register loads are not sign- or byte-adjusted; every access is a full 32-bit word.

## Timing
- Reset (clrn=0 at an edge):
  - All EXE/MEM fields go to 0.
  - state=IDLE, cnt=0, merr=0.
  - Next cycle: dmem_req=0, mstall=0, mwreg=0.
- Reset in WAIT abandons the access. dmem_req drops on the cycle after the reset edge, and no merr is raised.
- Latency:
  - An ALU op appears on the m-outputs one cycle after it is presented on the e-inputs.
  - A zero-wait load or store occupies exactly one M cycle.
  - An access with N wait cycles (dmem_ready low N cycles, then high) holds mstall=1 for N cycles.
- Handshake:
  - dmem_addr, dmem_we and dmem_wdata are stable for every cycle that dmem_req=1.
  - The request completes in the first cycle where dmem_req & dmem_ready.
  - dmem_ready while dmem_req=0 is ignored.
- Timeout: mstall is high for exactly TIMEOUT cycles. The following cycle is the abort/release cycle, with dmem_req=0.
- Back-to-back memory ops: the next op is evaluated in IDLE in the cycle immediately after release, with no bubble.
- All outputs except the m-register fields, merr, state and cnt are combinational from state, registers and dmem_ready.

## Test plan
- Reset: clrn=0 for 2 cycles with ewreg=1 → mwreg=0, malu=0, mrn=0, dmem_req=0, mstall=0, merr=0.
- ALU pass-through: ewreg=1, ealu=0x00001234, ern=5 → next cycle mwreg=1, malu=0x00001234, mrn=5, dmem_req=0.
- Zero-wait load: em2reg=1, ewreg=1, ealu=0x100, dmem_ready=1, dmem_rdata=0xCAFEF00D → same M cycle dmem_req=1, dmem_we=0, dmem_addr=0x100, mmo=0xCAFEF00D, mwreg=1, mstall=0.
- Store with 3 wait cycles: ewmem=1, ealu=0x200, eb=0x55AA55AA, dmem_ready low 3 cycles then high.
  - mstall=1 for 3 cycles, with dmem_we=1 and dmem_wdata=0x55AA55AA held throughout.
  - Different e-inputs applied during the stall are not captured.
  - They are captured on the edge after the ready cycle.
- Misaligned load: em2reg=1, ewreg=1, ealu=0x102 → dmem_req=0, mstall=0, mwreg=0; merr=1 from the next cycle onward.
- Timeout with TIMEOUT=4: load, dmem_ready held low → mstall=1 for 4 cycles, 5th cycle dmem_req=0, mwreg=0; merr=1 afterwards; next instruction proceeds.
